// File: rtl/parking_access_ctrl_mk2_if.sv
// Signal bundle between the entry sensors/keypad side and the parking gate controller.
// The slave modport is the controller's view; master is the driving environment.
interface parking_access_ctrl_mk2_if #(
  parameter int PSWD_W = 8,
  parameter int CNT_W  = 5,
  parameter int TRY_W  = 2
);
  logic              sensor_1;
  logic              sensor_2;
  logic              try_psswrd;
  logic [PSWD_W-1:0] psswrd_atmpt;
  logic              exit_pulse;
  logic              open_gate;
  logic              close_gate;
  logic              alarm_1;
  logic              alarm_2;
  logic              full;
  logic [CNT_W-1:0]  occupancy;
  logic [TRY_W-1:0]  fail_cnt;

  modport master (
    output sensor_1, sensor_2, try_psswrd, psswrd_atmpt, exit_pulse,
    input  open_gate, close_gate, alarm_1, alarm_2, full, occupancy, fail_cnt
  );

  modport slave (
    input  sensor_1, sensor_2, try_psswrd, psswrd_atmpt, exit_pulse,
    output open_gate, close_gate, alarm_1, alarm_2, full, occupancy, fail_cnt
  );
endinterface

// File: rtl/parking_access_ctrl_mk2.sv
// Parking entry gate controller: PIN check with lockout, tailgate block alarm,
// gate-open timeout and lot occupancy tracking. All outputs come from flops.
module parking_access_ctrl_mk2 #(
  parameter int              PSWD_W       = 8,
  parameter logic [PSWD_W-1:0] PSWD       = 'h57,
  parameter int              MAX_TRIES    = 3,
  parameter int              CAPACITY     = 16,
  parameter int              OPEN_TIMEOUT = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  parking_access_ctrl_mk2_if.slave bus
);
  localparam int CNT_W = $clog2(CAPACITY + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int TMR_W = $clog2(OPEN_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PIN,
    S_LOCKED,
    S_OPEN,
    S_BLOCK
  } state_t;

  state_t             state_q, state_d;
  logic               try_q, s2_q;
  logic [TRY_W-1:0]   fail_q, fail_d;
  logic [CNT_W-1:0]   occ_q, occ_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               open_q, close_q, alarm1_q, alarm2_q, full_q;
  logic               open_d, alarm1_d, alarm2_d;
  logic               att, ok, both, s2_rise, passed, inc, dec;

  assign att     = bus.try_psswrd & ~try_q;
  assign ok      = (bus.psswrd_atmpt == PSWD);
  assign both    = bus.sensor_1 & bus.sensor_2;
  assign s2_rise = bus.sensor_2 & ~s2_q;

  // State register plus every registered output and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      try_q    <= 1'b0;
      s2_q     <= 1'b0;
      fail_q   <= '0;
      occ_q    <= '0;
      timer_q  <= '0;
      open_q   <= 1'b0;
      close_q  <= 1'b1;
      alarm1_q <= 1'b0;
      alarm2_q <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      try_q    <= bus.try_psswrd;
      s2_q     <= bus.sensor_2;
      fail_q   <= fail_d;
      occ_q    <= occ_d;
      timer_q  <= timer_d;
      open_q   <= open_d;
      close_q  <= ~open_d;
      alarm1_q <= alarm1_d;
      alarm2_q <= alarm2_d;
      full_q   <= (occ_d == CNT_W'(CAPACITY));
    end
  end

  // Tailgate wins everywhere except LOCKED; a valid PIN is the only way out of an alarm.
  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    timer_d = '0;
    passed  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (both)
          state_d = S_BLOCK;
        else if (bus.sensor_1 && !full_q)
          state_d = S_PIN;
      end
      S_PIN: begin
        if (both) begin
          state_d = S_BLOCK;
        end else if (att) begin
          if (ok) begin
            state_d = S_OPEN;
            fail_d  = '0;
          end else begin
            fail_d = fail_q + 1'b1;
            if (fail_d == TRY_W'(MAX_TRIES))
              state_d = S_LOCKED;
          end
        end else if (!bus.sensor_1) begin
          state_d = S_IDLE;
          fail_d  = '0;
        end
      end
      S_LOCKED: begin
        if (att && ok) begin
          state_d = S_IDLE;
          fail_d  = '0;
        end
      end
      S_OPEN: begin
        if (both) begin
          state_d = S_BLOCK;
        end else if (s2_rise && !bus.sensor_1) begin
          state_d = S_IDLE;
          passed  = 1'b1;
        end else if (timer_q == TMR_W'(OPEN_TIMEOUT - 1)) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_BLOCK: begin
        if (att && ok)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    inc   = passed && (occ_q != CNT_W'(CAPACITY));
    dec   = bus.exit_pulse && (occ_q != '0);
    occ_d = occ_q;
    if (inc && !dec)
      occ_d = occ_q + 1'b1;
    else if (dec && !inc)
      occ_d = occ_q - 1'b1;
  end

  // Outputs are decoded from the upcoming state so they land in flops with it.
  always_comb begin
    open_d   = (state_d == S_OPEN);
    alarm1_d = (state_d == S_LOCKED);
    alarm2_d = (state_d == S_BLOCK);
  end

  assign bus.open_gate  = open_q;
  assign bus.close_gate = close_q;
  assign bus.alarm_1    = alarm1_q;
  assign bus.alarm_2    = alarm2_q;
  assign bus.full       = full_q;
  assign bus.occupancy  = occ_q;
  assign bus.fail_cnt   = fail_q;
endmodule

// File: tb/tb_parking_access_ctrl_mk2.sv
// Self-checking bench for parking_access_ctrl_mk2: directed scenarios followed by
// randomized traffic compared against a flag-based behavioural model of the gate.
module tb_parking_access_ctrl_mk2;
  localparam int TB_CAP  = 2;
  localparam int TB_TO   = 8;
  localparam int TB_MAX  = 3;
  localparam int CNT_W   = $clog2(TB_CAP + 1);
  localparam int TRY_W   = $clog2(TB_MAX + 1);
  localparam int VEC_W   = 5 + CNT_W + TRY_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  parking_access_ctrl_mk2_if #(.PSWD_W(8), .CNT_W(CNT_W), .TRY_W(TRY_W)) bus_if ();

  parking_access_ctrl_mk2 #(
    .PSWD_W(8), .PSWD(8'h57), .MAX_TRIES(TB_MAX),
    .CAPACITY(TB_CAP), .OPEN_TIMEOUT(TB_TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  bit m_try_q, m_s2_q, m_pin, m_open, m_locked, m_block;
  int m_fails, m_occ, m_age;

  // Behavioural model: the gate is in at most one mode, tracked with flags and counters.
  task automatic model_step(input bit r, s1, s2, tr, input logic [7:0] pw, input bit ex);
    bit att, ok, both, passed;
    att = tr && !m_try_q;
    ok = (pw == 8'h57);
    both = s1 && s2;
    passed = 0;
    if (r) begin
      {m_pin, m_open, m_locked, m_block} = '0;
      m_fails = 0; m_occ = 0; m_age = 0;
      m_try_q = 0; m_s2_q = 0;
    end else begin
      if (m_locked) begin
        if (att && ok) begin m_locked = 0; m_fails = 0; end
      end else if (m_block) begin
        if (att && ok) m_block = 0;
      end else if (both) begin
        m_pin = 0; m_open = 0; m_block = 1;
      end else if (m_open) begin
        if (s2 && !m_s2_q && !s1) begin passed = 1; m_open = 0; end
        else if (m_age == TB_TO - 1) m_open = 0;
        else m_age++;
      end else if (m_pin) begin
        if (att) begin
          if (ok) begin m_pin = 0; m_open = 1; m_age = 0; m_fails = 0; end
          else begin
            m_fails++;
            if (m_fails == TB_MAX) begin m_pin = 0; m_locked = 1; end
          end
        end else if (!s1) begin
          m_pin = 0; m_fails = 0;
        end
      end else if (s1 && m_occ != TB_CAP) begin
        m_pin = 1;
      end
      if (passed && !(ex && m_occ > 0)) m_occ = (m_occ < TB_CAP) ? m_occ + 1 : m_occ;
      else if (!passed && ex && m_occ > 0) m_occ--;
      m_try_q = tr;
      m_s2_q = s2;
    end
  endtask

  function automatic logic [VEC_W-1:0] model_vec();
    return {m_open, !m_open, m_locked, m_block, (m_occ == TB_CAP), CNT_W'(m_occ), TRY_W'(m_fails)};
  endfunction

  function automatic logic [VEC_W-1:0] dut_vec();
    return {bus_if.open_gate, bus_if.close_gate, bus_if.alarm_1, bus_if.alarm_2,
            bus_if.full, bus_if.occupancy, bus_if.fail_cnt};
  endfunction

  task automatic drive(input bit r, s1, s2, tr, input logic [7:0] pw, input bit ex);
    rst = r;
    bus_if.sensor_1 = s1;
    bus_if.sensor_2 = s2;
    bus_if.try_psswrd = tr;
    bus_if.psswrd_atmpt = pw;
    bus_if.exit_pulse = ex;
    @(posedge clk);
    model_step(r, s1, s2, tr, pw, ex);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 8'h00, 0);
    drive(1, 1, 1, 1, 8'h57, 1);
    n_checks++;
    if (dut_vec() !== {1'b0, 1'b1, 3'b000, CNT_W'(0), TRY_W'(0)}) begin
      n_fail++;
      $display("[TB] FAIL reset_state got=%b expected=%b", dut_vec(), {1'b0, 1'b1, 3'b000, CNT_W'(0), TRY_W'(0)});
    end
    drive(0, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic test_entry();
    drive(0, 1, 0, 0, 8'h00, 0);
    n_checks++;
    if (bus_if.open_gate !== 1'b0) begin
      n_fail++; $display("[TB] FAIL entry_wait_pin open_gate=%b expected=0", bus_if.open_gate);
    end
    drive(0, 1, 0, 1, 8'h57, 0);
    n_checks++;
    if ({bus_if.open_gate, bus_if.close_gate} !== 2'b10) begin
      n_fail++; $display("[TB] FAIL entry_open open/close=%b expected=10", {bus_if.open_gate, bus_if.close_gate});
    end
    drive(0, 0, 0, 0, 8'h00, 0);
    drive(0, 0, 1, 0, 8'h00, 0);
    n_checks++;
    if ({bus_if.open_gate, bus_if.occupancy} !== {1'b0, CNT_W'(1)}) begin
      n_fail++; $display("[TB] FAIL entry_pass open=%b occ=%0d expected open=0 occ=1", bus_if.open_gate, bus_if.occupancy);
    end
    drive(0, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic test_wrong_then_right();
    logic a1_seen = 1'b0;
    drive(0, 1, 0, 0, 8'h00, 0);
    for (int i = 1; i <= 2; i++) begin
      drive(0, 1, 0, 1, 8'h5F, 0);
      a1_seen |= bus_if.alarm_1;
      n_checks++;
      if (bus_if.fail_cnt !== TRY_W'(i)) begin
        n_fail++; $display("[TB] FAIL wrong_pin_count got=%0d expected=%0d", bus_if.fail_cnt, i);
      end
      drive(0, 1, 0, 0, 8'h00, 0);
      a1_seen |= bus_if.alarm_1;
    end
    drive(0, 1, 0, 1, 8'h57, 0);
    a1_seen |= bus_if.alarm_1;
    n_checks++;
    if ({bus_if.fail_cnt, bus_if.open_gate} !== {TRY_W'(0), 1'b1}) begin
      n_fail++; $display("[TB] FAIL right_pin fail_cnt=%0d open=%b expected 0/1", bus_if.fail_cnt, bus_if.open_gate);
    end
    drive(0, 0, 0, 0, 8'h00, 0);
    drive(0, 0, 1, 0, 8'h00, 0);
    drive(0, 0, 0, 0, 8'h00, 0);
    n_checks++;
    if ({a1_seen, bus_if.occupancy, bus_if.full} !== {1'b0, CNT_W'(2), 1'b1}) begin
      n_fail++; $display("[TB] FAIL second_entry alarm_1_seen=%b occ=%0d full=%b expected 0/2/1", a1_seen, bus_if.occupancy, bus_if.full);
    end
  endtask

  task automatic test_capacity();
    drive(0, 1, 0, 0, 8'h00, 0);
    drive(0, 1, 0, 1, 8'h57, 0);
    n_checks++;
    if ({bus_if.open_gate, bus_if.full} !== 2'b01) begin
      n_fail++; $display("[TB] FAIL full_refuse open=%b full=%b expected 0/1", bus_if.open_gate, bus_if.full);
    end
    drive(0, 0, 0, 0, 8'h00, 1);
    n_checks++;
    if ({bus_if.occupancy, bus_if.full} !== {CNT_W'(1), 1'b0}) begin
      n_fail++; $display("[TB] FAIL exit_dec occ=%0d full=%b expected 1/0", bus_if.occupancy, bus_if.full);
    end
    drive(0, 1, 0, 0, 8'h00, 0);
    drive(0, 1, 0, 1, 8'h57, 0);
    drive(0, 0, 0, 0, 8'h00, 0);
    drive(0, 0, 1, 0, 8'h00, 1);
    n_checks++;
    if ({bus_if.open_gate, bus_if.occupancy, bus_if.full} !== {1'b0, CNT_W'(1), 1'b0}) begin
      n_fail++; $display("[TB] FAIL pass_and_exit open=%b occ=%0d full=%b expected 0/1/0", bus_if.open_gate, bus_if.occupancy, bus_if.full);
    end
    drive(0, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic test_lockout();
    drive(0, 1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, 8'h5F, 0);
      drive(0, 1, 0, 0, 8'h00, 0);
    end
    n_checks++;
    if ({bus_if.alarm_1, bus_if.fail_cnt} !== {1'b1, TRY_W'(3)}) begin
      n_fail++; $display("[TB] FAIL lock_enter alarm_1=%b fail_cnt=%0d expected 1/3", bus_if.alarm_1, bus_if.fail_cnt);
    end
    drive(0, 1, 1, 1, 8'h5F, 0);
    n_checks++;
    if ({bus_if.alarm_1, bus_if.alarm_2, bus_if.fail_cnt, bus_if.open_gate} !== {2'b10, TRY_W'(3), 1'b0}) begin
      n_fail++; $display("[TB] FAIL lock_hold a1=%b a2=%b fail_cnt=%0d open=%b expected 1/0/3/0", bus_if.alarm_1, bus_if.alarm_2, bus_if.fail_cnt, bus_if.open_gate);
    end
    drive(0, 0, 0, 0, 8'h00, 0);
    drive(0, 0, 0, 1, 8'h57, 0);
    n_checks++;
    if ({bus_if.alarm_1, bus_if.fail_cnt, bus_if.open_gate} !== {1'b0, TRY_W'(0), 1'b0}) begin
      n_fail++; $display("[TB] FAIL unlock a1=%b fail_cnt=%0d open=%b expected 0/0/0", bus_if.alarm_1, bus_if.fail_cnt, bus_if.open_gate);
    end
    drive(0, 1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, 8'h5F, 0);
      drive(0, 1, 0, 0, 8'h00, 0);
    end
    drive(1, 1, 0, 0, 8'h00, 0);
    n_checks++;
    if (dut_vec() !== {1'b0, 1'b1, 3'b000, CNT_W'(0), TRY_W'(0)}) begin
      n_fail++; $display("[TB] FAIL reset_in_lock got=%b expected=%b", dut_vec(), {1'b0, 1'b1, 3'b000, CNT_W'(0), TRY_W'(0)});
    end
    drive(0, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic test_block();
    drive(0, 1, 1, 0, 8'h00, 0);
    n_checks++;
    if ({bus_if.alarm_2, bus_if.open_gate} !== 2'b10) begin
      n_fail++; $display("[TB] FAIL block_enter a2=%b open=%b expected 1/0", bus_if.alarm_2, bus_if.open_gate);
    end
    drive(0, 1, 1, 1, 8'h5F, 0);
    n_checks++;
    if ({bus_if.alarm_2, bus_if.fail_cnt} !== {1'b1, TRY_W'(0)}) begin
      n_fail++; $display("[TB] FAIL block_wrong a2=%b fail_cnt=%0d expected 1/0", bus_if.alarm_2, bus_if.fail_cnt);
    end
    drive(0, 0, 0, 0, 8'h00, 0);
    drive(0, 0, 0, 1, 8'h57, 0);
    n_checks++;
    if ({bus_if.alarm_2, bus_if.open_gate} !== 2'b00) begin
      n_fail++; $display("[TB] FAIL block_clear a2=%b open=%b expected 0/0", bus_if.alarm_2, bus_if.open_gate);
    end
    drive(0, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic test_timeout();
    int open_cycles = 0;
    logic [CNT_W-1:0] occ_before;
    occ_before = bus_if.occupancy;
    drive(0, 1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 1, 8'h5F, 0);
      n_checks++;
      if ({bus_if.fail_cnt, bus_if.alarm_1} !== {TRY_W'(1), 1'b0}) begin
        n_fail++; $display("[TB] FAIL held_strobe cycle=%0d fail_cnt=%0d a1=%b expected 1/0", i, bus_if.fail_cnt, bus_if.alarm_1);
      end
    end
    drive(0, 1, 0, 0, 8'h00, 0);
    drive(0, 1, 0, 1, 8'h57, 0);
    if (bus_if.open_gate === 1'b1) open_cycles++;
    for (int i = 0; i < TB_TO + 4; i++) begin
      drive(0, 0, 0, 0, 8'h00, 0);
      if (bus_if.open_gate === 1'b1) open_cycles++;
    end
    n_checks++;
    if (open_cycles != TB_TO) begin
      n_fail++; $display("[TB] FAIL open_timeout open_cycles=%0d expected=%0d", open_cycles, TB_TO);
    end
    n_checks++;
    if ({bus_if.occupancy, bus_if.close_gate} !== {occ_before, 1'b1}) begin
      n_fail++; $display("[TB] FAIL timeout_occ occ=%0d close=%b expected %0d/1", bus_if.occupancy, bus_if.close_gate, occ_before);
    end
  endtask

  task automatic test_random();
    bit r, s1, s2, tr, ex;
    logic [7:0] pw;
    int shown = 0;
    tr = 0;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(99) == 0);
      s1 = ($urandom_range(1) == 1);
      if (m_block) s1 = 0;
      s2 = ($urandom_range(2) == 0);
      if ($urandom_range(2) == 0) tr = !tr;
      pw = ($urandom_range(1) == 1) ? 8'h57 : 8'($urandom_range(255));
      ex = ($urandom_range(7) == 0);
      drive(r, s1, s2, tr, pw, ex);
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        if (shown < 20) begin
          shown++;
          $display("[TB] FAIL random_cycle_%0d got=%b expected=%b", i, dut_vec(), model_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_wrong_then_right();
    test_capacity();
    test_lockout();
    test_block();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
